// File: rtl/exp_1x1_kernal_loader.sv
// Write-side feeder for the expand 1x1 kernel FIFO: clears the FIFO, streams one layer of weights
// into it under occupancy throttling, then pulses done. Optional macro: EXP_1X1_LOADER_OVF_CHK_EN.
module exp_1x1_kernal_loader #(
  parameter int unsigned FIFO_DEPTH    = 256,
  parameter int unsigned SAFETY_MARGIN = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        exp_1x1_en_i,
  input  logic [10:0] tot_exp1_ker_word_limit_i,
  input  logic [63:0] ker_stream_data_i,
  input  logic        ker_stream_valid_i,
  output logic        ker_stream_ready_o,
  output logic        fifo_exp_1x1_clr_o,
  output logic [63:0] fifo_exp_1x1_wr_data_o,
  output logic        fifo_exp_1x1_wr_en_o,
  input  logic [7:0]  fifo_exp_1x1_data_count_i,
  output logic        load_busy_o,
  output logic        load_done_o,
  output logic        load_err_ovf_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StClear = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam int unsigned ReadyThresh = FIFO_DEPTH - SAFETY_MARGIN;

  logic [1:0]  state_q, state_d;
  logic [10:0] word_cnt_q, word_cnt_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        fifo_has_room;
  logic        accept;

  // The reserve below FIFO_DEPTH absorbs writes still in flight when the count catches up.
  assign fifo_has_room      = 32'(fifo_exp_1x1_data_count_i) < ReadyThresh;
  assign ker_stream_ready_o = (state_q == StLoad) && fifo_has_room;
  assign accept             = ker_stream_ready_o && ker_stream_valid_i;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = exp_1x1_en_i ? StClear : StDone;
        end
      end
      StClear: begin
        word_cnt_d = '0;
        state_d    = StLoad;
      end
      StLoad: begin
        if (accept) begin
          wr_en_d    = 1'b1;
          wr_data_d  = ker_stream_data_i;
          word_cnt_d = word_cnt_q + 11'd1;
          if (word_cnt_q == tot_exp1_ker_word_limit_i) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign fifo_exp_1x1_clr_o     = (state_q == StClear);
  assign fifo_exp_1x1_wr_data_o = wr_data_q;
  assign fifo_exp_1x1_wr_en_o   = wr_en_q;
  assign load_busy_o            = (state_q == StClear) || (state_q == StLoad);
  assign load_done_o            = (state_q == StDone);

`ifdef EXP_1X1_LOADER_OVF_CHK_EN
  localparam int unsigned OvfThresh = FIFO_DEPTH - 1;

  logic ovf_q, ovf_d;

  // Cleared on entry to CLEAR so the flag already reads 0 during the clear pulse.
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == StIdle) && start_i && exp_1x1_en_i) begin
      ovf_d = 1'b0;
    end else if (wr_en_q && (32'(fifo_exp_1x1_data_count_i) >= OvfThresh)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign load_err_ovf_o = ovf_q;
`else
  assign load_err_ovf_o = 1'b0;
`endif

endmodule
